config_loader: RTL and testbench
================================

# config_loader

Serial configuration loader for the 3x3 fabric. It accepts a framed bitstream one bit per handshake and validates a sync header. It then writes one 16-bit LUT configuration word into each of the NUM_TILES per-tile LUT SRAM registers in fixed tile order, and checks a closing XOR checksum. It sits between the external configuration port and the sramIn inputs of the LUT SRAM tiles. It drives a shared frame bus plus a one-hot per-tile write strobe.

## Interface
- NUM_TILES, 9: number of LUT SRAM tiles loaded per bitstream (1..16).
- FRAME_W, 16: bits per frame; equals LUT SRAM width.
- SYNC_WORD, 16'hA5C3: required header frame.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately.
- start  in  1  begin a load; sampled only in IDLE, DONE, ERR.
- bit_in  in  1  serial config bit, MSB of each frame first.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  loader accepts a bit this cycle.
- frame_out  out  FRAME_W  config word for the tile being written; registered, held between writes.
- tile_we  out  NUM_TILES  one-hot write strobe, bit k = tile k; one cycle per tile.
- busy  out  1  high in SYNC, LOAD, WRITE, CHECK.
- done  out  1  load completed and checksum matched; sticky until next start.
- err  out  1  sync or checksum failure; sticky until next start.

## Operation
- Bit accept = bit_valid && bit_ready. On accept: shreg <= {shreg[FRAME_W-2:0], bit_in}; bit_cnt++. A frame is complete on the accept with bit_cnt == FRAME_W-1, after which bit_cnt wraps to 0.
- bit_ready = 1 in SYNC, LOAD, CHECK; 0 in IDLE, WRITE, DONE, ERR. Bits offered while bit_ready=0 are ignored and not consumed.
- IDLE: on start -> SYNC. Clear bit_cnt, tile_idx, csum, done, err.
- DONE/ERR: on start -> SYNC, with the same clears. Otherwise stay.
- SYNC: frame complete with {shreg[14:0],bit_in} == SYNC_WORD -> LOAD. Any other value -> ERR.
- LOAD: frame complete -> WRITE. Latch the completed word into frame_out.
- WRITE (exactly 1 cycle):
  - tile_we = 1 << tile_idx.
  - csum <= csum ^ frame_out.
  - If tile_idx == NUM_TILES-1 -> CHECK; else tile_idx++ and -> LOAD.
- CHECK: frame complete with word == csum -> DONE; else -> ERR.
- tile_we is all-zero in every state except WRITE.
- No tile is written for sync or checksum frames.
- A checksum failure does not undo tiles already written. The fabric must treat err as "configuration invalid".
- start while busy is ignored.
- Reset (async, any state) puts the block in IDLE with:
  - frame_out = 0, tile_we = 0, bit_ready = 0, busy = 0, done = 0, err = 0.
  - shreg, bit_cnt, tile_idx, csum = 0.
- A partially shifted frame is discarded on reset.

## Timing
- start high at edge N: SYNC from edge N; bit_ready = 1 in cycle N+1.
- Last bit of a data frame accepted at edge M:
  - frame_out valid and tile_we pulsed during cycle M+1 (WRITE).
  - bit_ready = 1 again in cycle M+2.
- Last checksum bit accepted at edge M: done or err high from cycle M+1.
- Back-to-back valid bits: total load = 16 (sync) + NUM_TILES*17 + 16 (csum) cycles after SYNC entry. For NUM_TILES=9 this is 185 cycles.
- bit_valid gaps stall bit_cnt only; there is no timeout.
- frame_out and tile_we are registered or state-decoded, so there is no combinational path from bit_in.
- bit_ready is decoded from state only and does not depend on bit_valid.

## Test plan
- Clean load:
  - Stimulus: start, A5C3, tiles k=0..8 = 16'h1111*k, csum 16'h8888, bit_valid continuously high.
  - Required: tile_we = 9'h001..9'h100 in order, frame_out = 0000..8888, done = 1 at cycle 186 after SYNC entry, err = 0.
- Bad sync:
  - Stimulus: header 16'hA5C2.
  - Required: err = 1 one cycle after the 16th bit, no tile_we ever, bit_ready = 0.
  - Then start with the correct stream: done = 1.
- Bad checksum:
  - Stimulus: clean-load data with csum 16'h8889.
  - Required: all 9 tile_we pulses occur; err = 1, done = 0.
- Backpressure:
  - Stimulus: bit_valid toggling every cycle, plus random 0-5 cycle gaps.
  - Required: identical frame_out and tile_we sequence to clean load; bits offered during WRITE are not consumed.
- Reset mid-load:
  - Stimulus: assert reset (0) between clock edges after tile 3 is written and 7 bits of tile 4 are shifted.
  - Required: all outputs 0 without waiting for a clock edge; IDLE after release; a full reload succeeds.
- start while busy:
  - Stimulus: pulse start during LOAD of tile 2.
  - Required: no restart, tile order unaffected, done = 1.
  - A start in DONE clears done the next cycle.

Source files
------------

// File: rtl/config_loader.sv
// Serial configuration loader: validates a sync header, shifts one FRAME_W word per tile into
// the LUT SRAM tiles through a shared frame bus and one-hot strobe, then verifies an XOR checksum.
`timescale 1ns/1ps
module config_loader #(
    parameter int                 NUM_TILES = 9,
    parameter int                 FRAME_W   = 16,
    parameter logic [FRAME_W-1:0] SYNC_WORD = 16'hA5C3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [FRAME_W-1:0]   frame_out,
    output logic [NUM_TILES-1:0] tile_we,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int CNT_W = $clog2(FRAME_W);
    localparam int IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [IDX_W-1:0] LAST_TILE = IDX_W'(NUM_TILES - 1);

    typedef enum logic [2:0] {IDLE, SYNC, LOAD, WRITE, CHECK, DONE, ERR} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-2:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   tile_idx;
    logic [FRAME_W-1:0] csum;
    logic [FRAME_W-1:0] word;
    logic               accept;
    logic               frame_done;
    logic               restart;

    // Handshake decoded from state alone so bit_valid never feeds back into bit_ready.
    assign bit_ready  = (state == SYNC) || (state == LOAD) || (state == CHECK);
    assign busy       = bit_ready || (state == WRITE);
    assign accept     = bit_valid && bit_ready;
    assign frame_done = accept && (bit_cnt == LAST_BIT);
    assign word       = {shreg, bit_in};
    assign restart    = start && ((state == IDLE) || (state == DONE) || (state == ERR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tile_we   = '0;
        case (state)
            IDLE:  if (start) state_nxt = SYNC;
            SYNC:  if (frame_done) state_nxt = (word == SYNC_WORD) ? LOAD : ERR;
            LOAD:  if (frame_done) state_nxt = WRITE;
            WRITE: begin
                tile_we   = NUM_TILES'(1) << tile_idx;
                state_nxt = (tile_idx == LAST_TILE) ? CHECK : LOAD;
            end
            CHECK: if (frame_done) state_nxt = (word == csum) ? DONE : ERR;
            DONE:  if (start) state_nxt = SYNC;
            ERR:   if (start) state_nxt = SYNC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            tile_idx  <= '0;
            csum      <= '0;
            frame_out <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                shreg   <= {shreg[FRAME_W-3:0], bit_in};
                bit_cnt <= frame_done ? '0 : bit_cnt + 1'b1;
            end
            if (frame_done && (state == LOAD)) begin
                frame_out <= word;
            end
            if (state == WRITE) begin
                csum <= csum ^ frame_out;
                if (tile_idx != LAST_TILE) begin
                    tile_idx <= tile_idx + 1'b1;
                end
            end
            if (frame_done && (state == SYNC) && (word != SYNC_WORD)) begin
                err <= 1'b1;
            end
            if (frame_done && (state == CHECK)) begin
                done <= (word == csum);
                err  <= (word != csum);
            end
            // Restart only happens in states that never accept bits, so it cannot collide above.
            if (restart) begin
                bit_cnt  <= '0;
                tile_idx <= '0;
                csum     <= '0;
                done     <= 1'b0;
                err      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: clean load, bad sync, bad checksum, backpressure,
// start while busy, and asynchronous reset in the middle of a load.
`timescale 1ns/1ps
module tb_config_loader;
    logic        clk;
    logic        reset;
    logic        start;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic [15:0] frame_out;
    logic [8:0]  tile_we;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;
    logic [24:0] wq[$];

    config_loader #(.NUM_TILES(9), .FRAME_W(16), .SYNC_WORD(16'hA5C3)) dut (
        .clk(clk), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .frame_out(frame_out), .tile_we(tile_we), .busy(busy),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe with the frame presented alongside it.
    always @(negedge clk) begin
        if (reset && (tile_we != 9'd0)) wq.push_back({tile_we, frame_out});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit bp, input logic st);
        int waits;
        if (bp) begin
            bit_valid = 1'b0;
            repeat (1 + $urandom_range(0, 5)) @(negedge clk);
        end
        waits = 0;
        // Offer an inverted bit while the loader is not ready; it must be ignored.
        while ((bit_ready !== 1'b1) && (waits < 64)) begin
            bit_valid = 1'b1;
            bit_in    = ~b;
            @(negedge clk);
            waits++;
        end
        if (waits >= 64) begin
            n_fail++;
            $error("FAIL ready_timeout: observed bit_ready %b expected 1 within 64 cycles", bit_ready);
        end
        bit_valid = 1'b1;
        bit_in    = b;
        start     = st;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit bp, input int st_bit);
        for (int i = 15; i >= 0; i--) send_bit(w[i], bp, (i == st_bit));
    endtask

    task automatic send_stream(input logic [15:0] cs, input bit bp, input int st_tile);
        logic [15:0] w;
        send_word(16'hA5C3, bp, -1);
        for (int k = 0; k < 9; k++) begin
            w = 16'(16'h1111 * k);
            send_word(w, bp, (k == st_tile) ? 10 : -1);
        end
        send_word(cs, bp, -1);
        bit_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic check_tiles(input string tag);
        logic [8:0]  we_exp;
        logic [15:0] fo_exp;
        check($sformatf("%s_count", tag), wq.size(), 9);
        for (int k = 0; k < 9; k++) begin
            if (k < wq.size()) begin
                we_exp = 9'd1 << k;
                fo_exp = 16'(16'h1111 * k);
                check($sformatf("%s_we%0d", tag, k), wq[k][24:16], we_exp);
                check($sformatf("%s_fo%0d", tag, k), wq[k][15:0], fo_exp);
            end
        end
        wq.delete();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", bit_ready, 0);
        check("rst_we", tile_we, 0);
        check("rst_frame", frame_out, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        @(negedge clk);

        // Clean load, continuous valid.
        wq.delete();
        do_start();
        check("clean_busy", busy, 1);
        check("clean_ready", bit_ready, 1);
        send_stream(16'h8888, 1'b0, -1);
        check("clean_cycles", 32'(cyc - t0), 185);
        check("clean_done", done, 1);
        check("clean_err", err, 0);
        check("clean_busy_end", busy, 0);
        check_tiles("clean");

        // Bad sync header.
        do_start();
        for (int i = 15; i >= 1; i--) send_bit(1'(16'hA5C2 >> i), 1'b0, 1'b0);
        check("bsync_err_early", err, 0);
        send_bit(1'b0, 1'b0, 1'b0);
        bit_valid = 1'b0;
        check("bsync_err", err, 1);
        check("bsync_ready", bit_ready, 0);
        check("bsync_done", done, 0);
        repeat (3) @(negedge clk);
        check("bsync_no_we", wq.size(), 0);
        do_start();
        check("bsync_err_clr", err, 0);
        send_stream(16'h8888, 1'b0, -1);
        check("bsync_recover_done", done, 1);
        check_tiles("recover");

        // Bad checksum.
        do_start();
        send_stream(16'h8889, 1'b0, -1);
        check("bcs_err", err, 1);
        check("bcs_done", done, 0);
        check_tiles("bcs");

        // Backpressure with random gaps.
        do_start();
        send_stream(16'h8888, 1'b1, -1);
        check("bp_done", done, 1);
        check("bp_err", err, 0);
        check_tiles("bp");

        // Start pulsed during LOAD of tile 2 is ignored.
        do_start();
        send_stream(16'h8888, 1'b0, 2);
        check("swb_done", done, 1);
        check_tiles("swb");
        do_start();
        check("redo_done_clr", done, 0);
        check("redo_busy", busy, 1);

        // Reset after tile 3 written and 7 bits of tile 4 shifted.
        send_word(16'hA5C3, 1'b0, -1);
        for (int k = 0; k < 4; k++) send_word(16'(16'h1111 * k), 1'b0, -1);
        for (int i = 15; i >= 9; i--) send_bit(1'(16'h4444 >> i), 1'b0, 1'b0);
        bit_valid = 1'b0;
        check("mid_frame", frame_out, 16'h3333);
        check("mid_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", bit_ready, 0);
        check("arst_frame", frame_out, 0);
        check("arst_we", tile_we, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wq.delete();
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", bit_ready, 0);
        do_start();
        send_stream(16'h8888, 1'b0, -1);
        check("reload_done", done, 1);
        check("reload_err", err, 0);
        check_tiles("reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
